// File: rtl/decoder_pkg.sv
// Shared types and sizes for the round-robin select sequencer and its helpers.
package decoder_pkg;

    localparam int unsigned N_REQ = 4;
    localparam int unsigned SEL_W = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

endpackage : decoder_pkg

// File: rtl/rr_pick.sv
// Rotating-priority pick: first set request at or after (last+1), wrapping 3->0.
// Ports:
//   req     - request vector, bit i = requester i
//   last    - index of the most recent grantee
//   winner  - index of the chosen requester (0 when none)
//   any_req - at least one request is set
module rr_pick
    import decoder_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] last,
    output logic [SEL_W-1:0] winner,
    output logic             any_req
);

    logic [SEL_W-1:0] idx;
    logic             found;

    // Scan offsets 1..N_REQ; the 2-bit sum wraps, so offset N_REQ lands on last itself.
    always_comb begin
        winner  = '0;
        any_req = |req;
        found   = 1'b0;
        idx     = '0;
        for (int k = 1; k <= int'(N_REQ); k++) begin
            idx = last + SEL_W'(k);
            if (!found && req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

endmodule : rr_pick

// File: rtl/rr_select_sequencer.sv
// Round-robin arbiter driving a 2-to-4 one-hot decoder with break-before-make
// (one en=0 cycle between grants) and an optional per-grant hold limit.
// Ports:
//   clk, rst_n - clock (rising edge), asynchronous active-low reset
//   req        - request vector, bit i = requester i
//   release_i  - current grantee done; only looked at while granting
//   sel        - registered grant index (sel[1] -> ip1, sel[0] -> ip0)
//   en         - registered grant valid (decoder enable)
//   timeout    - one-cycle pulse when a grant is ended purely by the hold limit
module rr_select_sequencer
    import decoder_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned CNT_W    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             release_i,
    output logic [SEL_W-1:0] sel,
    output logic             en,
    output logic             timeout
);

    state_t           state, state_nx;
    logic [SEL_W-1:0] sel_nx;
    logic             en_nx;
    logic             timeout_nx;
    logic [CNT_W-1:0] hold_cnt, hold_nx;
    logic [SEL_W-1:0] last, last_nx;

    logic [SEL_W-1:0] winner;
    logic             any_req;
    logic             expire_c;
    logic             withdraw_c;

    // Single arbiter shared by the IDLE and GAP decisions.
    rr_pick u_pick (
        .req     (req),
        .last    (last),
        .winner  (winner),
        .any_req (any_req)
    );

    assign expire_c   = (MAX_HOLD != 0) && (hold_cnt == CNT_W'(MAX_HOLD - 1));
    assign withdraw_c = ~req[sel];

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            sel      <= '0;
            en       <= 1'b0;
            timeout  <= 1'b0;
            hold_cnt <= '0;
            last     <= SEL_W'(N_REQ - 1);
        end else begin
            state    <= state_nx;
            sel      <= sel_nx;
            en       <= en_nx;
            timeout  <= timeout_nx;
            hold_cnt <= hold_nx;
            last     <= last_nx;
        end
    end

    // Next-state and next-output decode.
    always_comb begin
        state_nx   = state;
        sel_nx     = sel;
        en_nx      = en;
        timeout_nx = 1'b0;
        hold_nx    = hold_cnt;
        last_nx    = last;

        case (state)
            IDLE, GAP: begin
                en_nx = 1'b0;
                if (any_req) begin
                    sel_nx   = winner;
                    en_nx    = 1'b1;
                    hold_nx  = '0;
                    state_nx = GRANT;
                end else begin
                    state_nx = IDLE;
                end
            end

            GRANT: begin
                // Saturate so an unlimited hold never wraps.
                if (hold_cnt != '1) begin
                    hold_nx = hold_cnt + CNT_W'(1);
                end
                if (release_i || withdraw_c || expire_c) begin
                    en_nx      = 1'b0;
                    last_nx    = sel;
                    timeout_nx = expire_c && !release_i && !withdraw_c;
                    state_nx   = GAP;
                end
            end

            default: begin
                en_nx    = 1'b0;
                state_nx = IDLE;
            end
        endcase
    end

endmodule : rr_select_sequencer

// File: tb/tb_rr_select_sequencer.sv
// Scoreboard bench for rr_select_sequencer: a behavioural model predicts
// sel/en/timeout after every clock edge, a monitor compares one cycle later.
module tb_rr_select_sequencer;

    localparam int unsigned MAX_HOLD = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = 4'b0000;
    logic       release_i = 1'b0;
    logic [1:0] sel;
    logic       en;
    logic       timeout;

    rr_select_sequencer #(.MAX_HOLD(MAX_HOLD), .CNT_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .release_i (release_i),
        .sel       (sel),
        .en        (en),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] sel;
        logic       en;
        logic       to;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Model state: owner = current grantee (-1 when nobody holds a grant),
    // held = grant cycles already completed by the owner.
    int m_owner = -1;
    int m_held  = 0;
    int m_last  = 3;
    int m_sel   = 0;
    bit m_to    = 1'b0;

    // Reference model: one decision per edge, expressed directly from the rules.
    always @(posedge clk) begin : model
        int o, h, l, s;
        bit t, done, exp_hit;
        o = m_owner; h = m_held; l = m_last; s = m_sel; t = 1'b0;
        if (!rst_n) begin
            o = -1; h = 0; l = 3; s = 0;
        end else if (o >= 0) begin
            h = h + 1;
            exp_hit = (MAX_HOLD != 0) && (h == int'(MAX_HOLD));
            done = release_i || !req[o] || exp_hit;
            if (done) begin
                t = exp_hit && !release_i && req[o];
                l = o;
                o = -1;
            end
        end else begin
            for (int k = 1; k <= 4; k++) begin
                int idx;
                idx = (l + k) % 4;
                if (req[idx]) begin
                    o = idx; s = idx; h = 0;
                    break;
                end
            end
        end
        q.push_back('{sel: 2'(s), en: (o >= 0), to: t});
        m_owner <= o;
        m_held  <= h;
        m_last  <= l;
        m_sel   <= s;
        m_to    <= t;
    end

    // Monitor: outputs are registered, so they are valid every cycle just after the edge.
    always @(posedge clk) begin : monitor
        exp_t e;
        #1;
        n_tests++;
        if (q.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty t=%0t: no expected entry", $time);
        end else begin
            e = q.pop_front();
            if ({sel, en, timeout} !== {e.sel, e.en, e.to}) begin
                n_fail++;
                $display("FAIL cycle t=%0t: got sel=%0d en=%0b timeout=%0b, expected sel=%0d en=%0b timeout=%0b",
                         $time, sel, en, timeout, e.sel, e.en, e.to);
            end
        end
    end

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Wait (bounded) until the model says 'who' has held for 'held' completed cycles.
    task automatic wait_owner(input int who, input int held);
        int budget;
        budget = 40;
        @(negedge clk);
        while (!(m_owner == who && m_held == held) && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        n_tests++;
        if (budget == 0) begin
            n_fail++;
            $display("FAIL wait_owner: got owner=%0d held=%0d, expected owner=%0d held=%0d",
                     m_owner, m_held, who, held);
        end
    endtask

    task automatic check_now(input string name, input logic [3:0] got, input logic [3:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    initial begin
        // Reset, then idle with no requests.
        rst_n = 1'b0;
        cycles(3);
        rst_n = 1'b1;
        cycles(10);
        check_now("idle_en", {3'b0, en}, 4'h0);
        check_now("idle_sel", {2'b0, sel}, 4'h0);

        // Lone request from 3 granted one edge later.
        req = 4'b1000;
        cycles(4);
        req = 4'b0000;
        cycles(3);

        // All requesting, release on every 3rd grant cycle.
        req = 4'b1111;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            release_i = (m_owner >= 0) && (m_held == 2);
        end
        release_i = 1'b0;

        // Single requester held: expiry, gap, re-grant.
        req = 4'b0100;
        cycles(25);

        // Withdrawal mid-grant hands over to 3 after 1.
        req = 4'b0010;
        wait_owner(1, 0);
        req = 4'b1001;
        cycles(6);

        // Release coincides with expiry: no timeout pulse.
        req = 4'b0001;
        wait_owner(0, int'(MAX_HOLD) - 1);
        release_i = 1'b1;
        @(negedge clk);
        release_i = 1'b0;
        cycles(4);

        // Async reset mid-grant clears outputs without a clock edge.
        req = 4'b0100;
        wait_owner(2, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_now("async_en", {3'b0, en}, 4'h0);
        check_now("async_sel", {2'b0, sel}, 4'h0);
        check_now("async_timeout", {3'b0, timeout}, 4'h0);
        req = 4'b0101;
        cycles(2);
        rst_n = 1'b1;
        cycles(8);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 2) == 0) req = 4'($urandom_range(0, 15));
            release_i = ($urandom_range(0, 4) == 0);
        end
        release_i = 1'b0;
        req = 4'b0000;
        cycles(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_rr_select_sequencer

// File: doc/rr_select_sequencer.md
Name: rr_select_sequencer

Overview:
- Round-robin arbiter that drives the 2-to-4 one-hot decoder directly upstream of it.
- Arbitrates among 4 requesters and emits a registered 2-bit grant index `sel` (to decoder ip1:ip0) and a grant enable `en` (to decoder en).
- Enforces break-before-make: there is one all-zero `en` cycle between grants.
- Enforces an optional maximum hold time per grant.

Parameters:
- MAX_HOLD, 8, maximum consecutive GRANT cycles per grant; 0 = unlimited.
- CNT_W, 4, hold-counter width; must satisfy 2**CNT_W >= MAX_HOLD.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  4  request vector; bit i = requester i.
- release_i  input  1  current grantee done; sampled only in GRANT.
- sel  output  2  registered grant index; sel[1] drives ip1, sel[0] drives ip0.
- en  output  1  registered grant valid; drives decoder en.
- timeout  output  1  one-cycle pulse when a grant is force-ended by MAX_HOLD.

Behaviour:
- Reset (async, any state, mid-grant included):
  - state=IDLE, sel=2'd0, en=0, timeout=0, hold_cnt=0.
  - last=2'd3, so req[0] has highest priority after reset.
- All outputs are registered, with no combinational path from inputs to outputs.
- Rotating priority: search req starting at index (last+1) mod 4, ascending with wrap 3->0. The first set bit wins.
- States:
  - IDLE: en=0.
    - If req != 0: sel <= winner, en <= 1, hold_cnt <= 0, go GRANT.
    - Else stay. sel holds its previous value (no toggling while idle).
  - GRANT: en=1, sel stable for the whole grant, hold_cnt increments each cycle.
    - End conditions (any of):
      - release_i=1
      - req[sel]=0 (requester withdrew)
      - MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1
    - On end: en <= 0, last <= sel, go GAP.
    - timeout <= 1 only when expiry is the sole end condition (release_i=0 and req[sel]=1).
  - GAP: en=0 for exactly one cycle; timeout returns to 0.
    - Arbitration runs using the updated last.
    - If req != 0: sel <= winner, en <= 1, go GRANT. Else go IDLE.
- Latency:
  - req rising in IDLE at edge t gives en=1 after edge t+1.
  - Grant end sampled at edge t gives en=0 after t+1 and the next grant's en=1 after t+2.
- Single requester held continuously: same index re-granted after each GAP, since it is the only request.
- With MAX_HOLD=0, the hold counter saturates and never triggers timeout.
- Simultaneous events:
  - release_i together with expiry → no timeout pulse.
  - release_i outside GRANT → ignored.
  - req changes during GRANT for non-granted bits → no effect until the next arbitration.
- Invariant: the decoder sees an en=0 cycle between any two different sel values while en=1.

Decomposition:
- Shared package `decoder_pkg`:
  - N_REQ=4, SEL_W=2.
  - state enum {IDLE, GRANT, GAP}.
- One natural sub-module, `rr_pick`: purely combinational, inputs req[3:0] and last[1:0], outputs winner[1:0] and any_req.
  - Instantiated once, shared by the IDLE and GAP decisions.

Test Plan:
1. Reset then req=4'b1111 held, release_i pulsed 1 cycle every 3rd GRANT cycle → sel sequence 0,1,2,3,0 with en pattern 1,1,1,0 repeating; timeout never asserted.
2. MAX_HOLD=8, req=4'b0100 held, no release → en high exactly 8 cycles, timeout=1 on the first GAP cycle, en=0 for one cycle, then sel=2 re-granted.
3. Grant on sel=1, then req[1] drops mid-grant while req=4'b1001 → en=0 next cycle, then sel=3 granted (3 follows 1 in rotation).
4. Release and expiry on the same cycle (MAX_HOLD=4, release_i=1 at 4th GRANT cycle) → en=0 next cycle, timeout stays 0.
5. Async rst_n low mid-GRANT (sel=2, en=1) → en=0, sel=0, timeout=0 immediately, without a clock edge; after release with req=4'b0101, sel=0 granted first.
6. req=0 after reset for 10 cycles → en=0, sel=0, state IDLE throughout; then req=4'b1000 → en=1 with sel=3 one edge later.
